// File: rtl/mem_if_pkg.sv
// Shared types and constants for the unified-memory bridge.
// Covers FSM states, access kinds, load/store size encodings and the reset instruction.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } kind_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_if_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_interface.sv
// Bridges fetch/load/store requests from the multi-cycle core to a single memory port
// with a ready handshake, stalling the core while an access is in flight.
module mem_interface #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR  = mem_if_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic                  adr_src,
  input  logic                  ir_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           store_data,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] old_pc,
  output logic [31:0]           read_data,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  import mem_if_pkg::*;

  state_t                state, state_nxt;
  kind_t                 kind_q, kind_c;
  logic [1:0]            offset_q;
  logic [2:0]            funct3_q;
  logic                  req_c, mis_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [3:0]            be_c;
  logic [31:0]           wdata_c;
  logic [31:0]           load_data;

  assign req_c  = ir_write | mem_write | mem_read;
  assign addr_c = adr_src ? alu_result : pc;

  // Request decode: priority, lanes, replicated write data and alignment.
  always_comb begin
    kind_c  = LOAD;
    mis_c   = 1'b0;
    be_c    = 4'b1111;
    wdata_c = store_data;
    if (ir_write)       kind_c = FETCH;
    else if (mem_write) kind_c = STORE;

    case (kind_c)
      FETCH: mis_c = (pc[1:0] != 2'b00);
      STORE: begin
        case (funct3)
          F3_B: begin
            be_c    = 4'b0001 << addr_c[1:0];
            wdata_c = {4{store_data[7:0]}};
          end
          F3_H: begin
            be_c    = addr_c[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{store_data[15:0]}};
            mis_c   = addr_c[0];
          end
          default: mis_c = (addr_c[1:0] != 2'b00);
        endcase
      end
      default: begin
        case (funct3)
          F3_B, F3_BU: mis_c = 1'b0;
          F3_H, F3_HU: mis_c = addr_c[0];
          default:     mis_c = (addr_c[1:0] != 2'b00);
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_c) state_nxt = mis_c ? DONE : BUSY;
      BUSY:    if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational so the core freezes in the same cycle it raises a request.
  assign stall = ((state == IDLE) && req_c) || (state == BUSY);

  mem_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Request registers and capture of fetched/loaded data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind_q     <= FETCH;
      offset_q   <= 2'd0;
      funct3_q   <= 3'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'd0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      read_data  <= 32'd0;
      old_pc     <= '0;
      misaligned <= 1'b0;
      instr      <= NOP_INSTR;
    end else begin
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (req_c) begin
            kind_q     <= kind_c;
            offset_q   <= addr_c[1:0];
            funct3_q   <= funct3;
            mem_addr   <= {addr_c[ADDR_WIDTH-1:2], 2'b00};
            mem_we     <= (kind_c == STORE) && !mis_c;
            mem_be     <= be_c;
            mem_wdata  <= wdata_c;
            mem_req    <= !mis_c;
            misaligned <= mis_c;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (kind_q)
              FETCH: begin
                instr  <= mem_rdata;
                old_pc <= pc;
              end
              LOAD:    read_data <= load_data;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Randomized scoreboard bench for mem_interface: a driver acting as the core, a memory
// responder with configurable wait states, and a monitor checking against a word-level model.
module tb_mem_interface;
  import mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, alu_result;
  logic        adr_src, ir_write, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] store_data;
  logic [31:0] instr, old_pc, read_data;
  logic        stall, misaligned, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_interface #(.ADDR_WIDTH(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .alu_result (alu_result),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .store_data (store_data),
    .instr      (instr),
    .old_pc     (old_pc),
    .read_data  (read_data),
    .stall      (stall),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    bit          mis;
    bit          store;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_instr, m_oldpc, m_rdata;
  bit          resp_en  = 1'b1;
  int          wait_cfg = 0;
  logic [31:0] rdata_cfg = 32'd0;
  int          resp_cnt = 0;
  bit          done_pend = 1'b0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Word-level load model: shift the addressed lanes down, mask to size, extend.
  function automatic logic [31:0] extract(input logic [31:0] w, input int off, input int size,
                                          input bit sgn);
    logic [31:0] v, mask;
    v    = w >> (8 * off);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v    = v & mask;
    if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  // Memory responder: raises mem_ready after wait_cfg BUSY cycles, random noise otherwise.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        if (mem_req === 1'b1) begin
          if (resp_cnt == wait_cfg) begin
            mem_ready = 1'b1;
            mem_rdata = rdata_cfg;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
          end
          resp_cnt++;
        end else begin
          resp_cnt  = 0;
          mem_ready = ($urandom_range(0, 3) == 0);
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: checks request fields on every BUSY cycle and results on every DONE cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        done_pend = 1'b0;
        continue;
      end
      if (mem_req === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_req: got mem_req=1 expected no access in flight");
        end else begin
          mon_e = sb_q[0];
          check("mem_addr", mem_addr, mon_e.addr);
          check("mem_we", 32'(mem_we), 32'(mon_e.we));
          check("busy_stall", 32'(stall), 32'd1);
          if (mon_e.store) begin
            check("mem_be", 32'(mem_be), 32'(mon_e.be));
            check("mem_wdata", mem_wdata, mon_e.wdata);
          end
        end
      end
      if (misaligned === 1'b1 || done_pend) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got completion expected none pending");
        end else begin
          mon_e = sb_q.pop_front();
          check("misaligned", 32'(misaligned), 32'(mon_e.mis));
          check("done_stall", 32'(stall), 32'd0);
          check("done_req", 32'(mem_req), 32'd0);
          check("instr", instr, mon_e.instr);
          check("old_pc", old_pc, mon_e.old_pc);
          check("read_data", read_data, mon_e.rdata);
        end
      end
      done_pend = (mem_req === 1'b1) && (mem_ready === 1'b1);
    end
  end

  task automatic clear_req();
    ir_write  = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  // One core access: model the expected outcome, issue it, and time the stall.
  task automatic access(input bit f, input bit w, input bit r, input logic [31:0] pcv,
                        input logic [31:0] alu, input logic [2:0] f3, input logic [31:0] sd,
                        input int nw, input logic [31:0] rd);
    exp_t        e;
    logic [31:0] addr;
    int          size, off, lat;
    bit          is_store, is_load, asrc;
    is_store = !f && w;
    is_load  = !f && !w;
    asrc     = !f;
    addr     = asrc ? alu : pcv;
    off      = int'(addr % 32'd4);
    if (f)             size = 4;
    else if (is_store) size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    else               size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.mis   = f ? (pcv % 32'd4 != 0) : (addr % 32'(size) != 0);
    e.store = is_store;
    e.we    = is_store;
    e.addr  = addr & ~32'h3;
    e.be    = 4'(((1 << size) - 1) << off);
    e.wdata = (size == 1) ? sd[7:0] * 32'h0101_0101 :
              (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    if (!e.mis) begin
      if (f) begin
        m_instr = rd;
        m_oldpc = pcv;
      end else if (is_load) begin
        m_rdata = extract(rd, off, size, !f3[2]);
      end
    end
    e.instr  = m_instr;
    e.old_pc = m_oldpc;
    e.rdata  = m_rdata;
    sb_q.push_back(e);
    wait_cfg  = nw;
    rdata_cfg = rd;

    @(posedge clk);
    #2;
    ir_write = f; mem_write = w; mem_read = r;
    pc = pcv; alu_result = alu; adr_src = asrc; funct3 = f3; store_data = sd;
    lat = 0;
    forever begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      lat++;
      if (lat > 200) begin
        n_checks++;
        $display("FAIL stall_timeout: got stall stuck high expected release");
        break;
      end
    end
    check("stall_cycles", 32'(lat), e.mis ? 32'd1 : 32'(2 + nw));
    @(posedge clk);
    #2;
    clear_req();
  endtask

  task automatic reset_mid_busy();
    exp_t e;
    int   n;
    e.mis = 1'b0; e.store = 1'b0; e.we = 1'b0; e.addr = 32'h40; e.be = 4'hF;
    e.wdata = 32'd0; e.instr = m_instr; e.old_pc = m_oldpc; e.rdata = m_rdata;
    sb_q.push_back(e);
    resp_en   = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #2;
    mem_read = 1'b1; adr_src = 1'b1; alu_result = 32'h40; funct3 = F3_W;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_req !== 1'b1 && n < 20);
    check("rst_reached_busy", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    sb_q.delete();
    m_instr = NOP_INSTR; m_oldpc = 32'd0; m_rdata = 32'd0;
    check("rst_req_drop", 32'(mem_req), 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_stall_follows_req", 32'(stall), 32'd1);
    mem_ready = 1'b1;
    clear_req();
    repeat (2) begin
      @(negedge clk);
      check("rst_late_ready", 32'(mem_req), 32'd0);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_req", 32'(mem_req), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_instr", instr, 32'h0000_0013);
    check("post_rst_rdata", read_data, 32'd0);
    mem_ready = 1'b0;
    resp_en   = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] pcv, alu;
    bit          f, w, r;
    reset = 1'b0;
    pc = 32'd0; alu_result = 32'd0; adr_src = 1'b0; funct3 = 3'd0; store_data = 32'd0;
    clear_req();
    m_instr = NOP_INSTR; m_oldpc = 32'd0; m_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_be", 32'(mem_be), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_read_data", read_data, 32'd0);
    check("reset_old_pc", old_pc, 32'd0);
    check("reset_misaligned", 32'(misaligned), 32'd0);
    check("reset_instr", instr, 32'h0000_0013);
    check("reset_stall_idle", 32'(stall), 32'd0);
    mem_read = 1'b1;
    #1;
    check("reset_stall_req", 32'(stall), 32'd1);
    clear_req();
    @(posedge clk);
    #2;
    reset = 1'b1;

    access(1, 0, 0, 32'h100, 32'h0, 3'd0, 32'd0, 0, 32'h0050_0093);
    access(0, 1, 0, 32'h104, 32'h203, F3_B, 32'h1234_5678, 1, 32'd0);
    access(0, 0, 1, 32'h108, 32'h3, F3_B, 32'd0, 0, 32'h80FF_0000);
    access(0, 0, 1, 32'h10C, 32'h3, F3_BU, 32'd0, 2, 32'h80FF_0000);
    access(0, 0, 1, 32'h110, 32'h5, F3_H, 32'd0, 0, 32'hDEAD_BEEF);
    access(0, 0, 1, 32'h114, 32'h40, F3_W, 32'd0, 3, 32'hCAFE_F00D);
    access(0, 1, 0, 32'h118, 32'h42, F3_H, 32'hAAAA_8001, 0, 32'd0);
    access(1, 1, 1, 32'h200, 32'h300, F3_W, 32'h5555_5555, 1, 32'h0010_0113);
    access(0, 1, 1, 32'h204, 32'h308, F3_W, 32'h0BAD_CAFE, 0, 32'd0);
    access(1, 0, 0, 32'h202, 32'h0, 3'd0, 32'd0, 0, 32'hFFFF_FFFF);
    reset_mid_busy();
    access(1, 0, 0, 32'h400, 32'h0, 3'd0, 32'd0, 1, 32'h0000_8067);

    for (int i = 0; i < 150; i++) begin
      f = ($urandom_range(0, 2) == 0);
      w = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 1) == 1;
      if (!f && !w) r = 1'b1;
      pcv = $urandom;
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) pcv[1:0] = 2'b00;
      access(f, w, r, pcv, alu, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 4),
             $urandom);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
